// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Brief    : Shared types and constants for the RMII receive path: deframer
//            state encoding, preamble/SFD dibits, CRC-32 constants and the
//            byte-wide CRC-32 update function.
// Revision : 1.0 - initial release
// ============================================================================
package eth_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      DROP     = 2'd3
   } rx_state_t;

   localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0]  SFD_DIBIT      = 2'b11;

   localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
   // Residue expressed in MSB-first bit order.
   localparam logic [31:0] CRC32_RESIDUE  = 32'hC704DD7B;

   localparam int          ETH_MIN_FRAME  = 64;

   // Bit-reverse a 32-bit word (LSB-first register <-> MSB-first notation).
   function automatic logic [31:0] reverse32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   // Reflected CRC-32 update over one byte, LSB of the byte processed first.
   function automatic logic [31:0] crc32_next_byte(input logic [31:0] crc,
                                                   input logic [7:0]  d);
      logic [31:0] c;
      logic [31:0] poly_r;
      poly_r = reverse32(CRC32_POLY);
      c      = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) begin
            c = (c >> 1) ^ poly_r;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_crc32.sv
`default_nettype none
// ============================================================================
// Module   : eth_crc32
// Brief    : Byte-wide reflected CRC-32 accumulator with synchronous clear
//            and enable. Register holds the raw (non-inverted) CRC state.
// Revision : 1.0 - initial release
// ============================================================================
module eth_crc32
   import eth_pkg::*;
(
   input  logic        clk_50_mhz,
   input  logic        rst_n,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] r_crc;

   // Restart on clear, fold in one byte whenever enabled.
   always_ff @(posedge clk_50_mhz) begin
      if (!rst_n || i_clr) begin
         r_crc <= CRC32_INIT;
      end else if (i_en) begin
         r_crc <= crc32_next_byte(r_crc, i_data);
      end
   end

   assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/rmii_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : rmii_rx_deframer
// Brief    : RMII receive front end. Registers rx_d/crs_dv/rx_er, hunts for
//            preamble + SFD, assembles LSB-first dibits into bytes and emits
//            a byte stream with sof/eof/err framing and a frame byte count.
//            Optional FCS/runt checking when RMII_RX_FCS_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rmii_rx_deframer
   import eth_pkg::*;
#(
   parameter int MIN_PREAMBLE_DIBITS = 8,
   parameter int MAX_FRAME_BYTES     = 1522
)(
   input  logic        clk_50_mhz,
   input  logic        rst_n,
   input  logic        rx_er,
   input  logic [1:0]  rx_d,
   input  logic        crs_dv,
   output logic [7:0]  data_o,
   output logic        valid_o,
   output logic        sof_o,
   output logic        eof_o,
   output logic        err_o,
   output logic [15:0] byte_count_o
);

   localparam logic [7:0]  c_MIN_PRE = 8'(MIN_PREAMBLE_DIBITS);
   localparam logic [15:0] c_MAX     = 16'(MAX_FRAME_BYTES);

   logic [1:0] r_rx_d;
   logic       r_crs_dv;
   logic       r_rx_er;

   rx_state_t  r_state;
   logic [7:0] r_pre_cnt;
   logic [1:0] r_dib_idx;
   logic [5:0] r_shift;
   // One-dibit hold stage: a low crs_dv sample is only known to be data once
   // the following sample shows crs_dv high again (RMII end-of-frame toggle).
   logic [1:0] r_hold_d;
   logic       r_hold_dv;
   logic       r_hold_vld;
   logic       r_err_sticky;
   logic       r_first;

   logic       w_sfd;
   logic       w_eof_det;
   logic       w_accept;
   logic       w_byte_done;
   logic       w_oversize;
   logic       w_deliver;
   logic [7:0] w_byte;
   logic       w_fcs_err;

   // Sample the PHY interface once; the FSM works only on registered inputs.
   always_ff @(posedge clk_50_mhz) begin
      if (!rst_n) begin
         r_rx_d   <= 2'b00;
         r_crs_dv <= 1'b0;
         r_rx_er  <= 1'b0;
      end else begin
         r_rx_d   <= rx_d;
         r_crs_dv <= crs_dv;
         r_rx_er  <= rx_er;
      end
   end

   // Decode SFD, end-of-frame and dibit acceptance from the hold stage.
   always_comb begin
      w_sfd       = (r_state == PREAMBLE) && r_crs_dv &&
                    (r_rx_d == SFD_DIBIT) && (r_pre_cnt >= c_MIN_PRE);
      w_eof_det   = ((r_state == DATA) || (r_state == DROP)) &&
                    r_hold_vld && !r_hold_dv && !r_crs_dv;
      w_accept    = (r_state == DATA) && r_hold_vld && !w_eof_det;
      w_byte_done = w_accept && (r_dib_idx == 2'd3);
      w_byte      = {r_hold_d, r_shift};
      w_oversize  = w_byte_done && (byte_count_o == c_MAX);
      w_deliver   = w_byte_done && !w_oversize;
   end

`ifdef RMII_RX_FCS_CHECK_EN
   logic [31:0] w_crc;

   eth_crc32 u_crc (
      .clk_50_mhz (clk_50_mhz),
      .rst_n      (rst_n),
      .i_clr      (w_sfd),
      .i_en       (w_deliver),
      .i_data     (w_byte),
      .o_crc      (w_crc)
   );

   assign w_fcs_err = (reverse32(w_crc) != CRC32_RESIDUE) ||
                      (byte_count_o < 16'(ETH_MIN_FRAME));
`else
   assign w_fcs_err = 1'b0;
`endif

   // Deframer FSM with registered byte/framing outputs.
   always_ff @(posedge clk_50_mhz) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pre_cnt    <= 8'd0;
         r_dib_idx    <= 2'd0;
         r_shift      <= 6'd0;
         r_hold_d     <= 2'b00;
         r_hold_dv    <= 1'b0;
         r_hold_vld   <= 1'b0;
         r_err_sticky <= 1'b0;
         r_first      <= 1'b0;
         data_o       <= 8'd0;
         valid_o      <= 1'b0;
         sof_o        <= 1'b0;
         eof_o        <= 1'b0;
         err_o        <= 1'b0;
         byte_count_o <= 16'd0;
      end else begin
         valid_o <= 1'b0;
         sof_o   <= 1'b0;
         eof_o   <= 1'b0;
         err_o   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_crs_dv && (r_rx_d == PREAMBLE_DIBIT)) begin
                  r_state   <= PREAMBLE;
                  r_pre_cnt <= 8'd1;
               end
            end
            PREAMBLE: begin
               if (w_sfd) begin
                  r_state      <= DATA;
                  r_dib_idx    <= 2'd0;
                  r_hold_vld   <= 1'b0;
                  r_err_sticky <= 1'b0;
                  r_first      <= 1'b1;
                  byte_count_o <= 16'd0;
               end else if (r_crs_dv && (r_rx_d == PREAMBLE_DIBIT)) begin
                  if (r_pre_cnt != 8'hFF) begin
                     r_pre_cnt <= r_pre_cnt + 8'd1;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            DATA: begin
               if (r_crs_dv && r_rx_er) begin
                  r_err_sticky <= 1'b1;
               end
               if (w_eof_det) begin
                  eof_o   <= 1'b1;
                  err_o   <= r_err_sticky || (r_dib_idx != 2'd0) || w_fcs_err;
                  r_state <= IDLE;
               end else begin
                  r_hold_d   <= r_rx_d;
                  r_hold_dv  <= r_crs_dv;
                  r_hold_vld <= 1'b1;
                  if (w_accept) begin
                     r_dib_idx <= r_dib_idx + 2'd1;
                     r_shift   <= {r_hold_d, r_shift[5:2]};
                  end
                  if (w_oversize) begin
                     r_state      <= DROP;
                     r_err_sticky <= 1'b1;
                  end else if (w_deliver) begin
                     data_o       <= w_byte;
                     valid_o      <= 1'b1;
                     sof_o        <= r_first;
                     r_first      <= 1'b0;
                     byte_count_o <= byte_count_o + 16'd1;
                  end
               end
            end
            DROP: begin
               if (w_eof_det) begin
                  eof_o   <= 1'b1;
                  err_o   <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_hold_dv  <= r_crs_dv;
                  r_hold_vld <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rmii_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rmii_rx_deframer
// Brief    : Directed self-checking bench for rmii_rx_deframer. Frames are
//            built in a local array (FCS appended by a reference CRC-32),
//            driven as RMII dibits, and the byte stream is captured and
//            compared against the array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rmii_rx_deframer;

`ifdef RMII_RX_FCS_CHECK_EN
   localparam logic FCS_EN = 1'b1;
`else
   localparam logic FCS_EN = 1'b0;
`endif

   logic        clk_50_mhz = 1'b0;
   logic        rst_n      = 1'b0;
   logic        rx_er      = 1'b0;
   logic [1:0]  rx_d       = 2'b00;
   logic        crs_dv     = 1'b0;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        sof_o;
   logic        eof_o;
   logic        err_o;
   logic [15:0] byte_count_o;

   int tests  = 0;
   int failed = 0;

   logic [7:0] fr [2048];
   logic [7:0] got_q [$];
   int         sof_cnt   = 0;
   int         sof_idx   = -1;
   int         eof_cnt   = 0;
   logic       last_err  = 1'b0;
   int         overlap   = 0;
   int         stray_err = 0;

   rmii_rx_deframer dut (
      .clk_50_mhz   (clk_50_mhz),
      .rst_n        (rst_n),
      .rx_er        (rx_er),
      .rx_d         (rx_d),
      .crs_dv       (crs_dv),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .sof_o        (sof_o),
      .eof_o        (eof_o),
      .err_o        (err_o),
      .byte_count_o (byte_count_o)
   );

   always #10 clk_50_mhz = ~clk_50_mhz;

   // Capture the output stream away from the active edge.
   always @(negedge clk_50_mhz) begin
      if (valid_o) begin
         got_q.push_back(data_o);
         if (sof_o) begin
            sof_cnt++;
            if (sof_idx < 0) sof_idx = got_q.size() - 1;
         end
      end
      if (eof_o) begin
         eof_cnt++;
         last_err = err_o;
      end
      if (eof_o && valid_o) overlap++;
      if (!eof_o && err_o) stray_err++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] d, input logic dv, input logic er);
      @(posedge clk_50_mhz);
      #1;
      rx_d   = d;
      crs_dv = dv;
      rx_er  = er;
   endtask

   // Fill fr[0..n-1] with (start+i) and append a valid FCS; returns length.
   function automatic int build_frame(input int n, input int start);
      logic [31:0] c;
      for (int i = 0; i < n; i++) fr[i] = 8'(start + i);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, fr[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      fr[n]   = c[7:0];
      fr[n+1] = c[15:8];
      fr[n+2] = c[23:16];
      fr[n+3] = c[31:24];
      return n + 4;
   endfunction

   function automatic int data_errs(input int n);
      int e;
      e = 0;
      if (got_q.size() < n) return n;
      for (int i = 0; i < n; i++) if (got_q[i] !== fr[i]) e++;
      return e;
   endfunction

   task automatic clear_capture();
      got_q.delete();
      sof_cnt = 0;
      sof_idx = -1;
   endtask

   task automatic send_frame(input int npre, input int nbytes, input bit toggle,
                             input int er_byte, input int extra, input bit end_frame);
      logic dv;
      for (int i = 0; i < npre; i++) drive(2'b01, 1'b1, 1'b0);
      drive(2'b11, 1'b1, 1'b0);
      for (int i = 0; i < nbytes; i++) begin
         for (int k = 0; k < 4; k++) begin
            dv = 1'b1;
            if (toggle && (i >= nbytes - 2)) dv = k[0];
            drive(fr[i][2*k +: 2], dv, (i == er_byte) && (k == 0));
         end
      end
      for (int i = 0; i < extra; i++) drive(2'b10, 1'b1, 1'b0);
      if (end_frame) begin
         drive(2'b00, 1'b0, 1'b0);
         drive(2'b00, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int n;
      int eof_before;

      // ---------------- reset ----------------
      repeat (5) @(posedge clk_50_mhz);
      #1;
      chk("rst_data",  {24'h0, data_o}, 32'h0);
      chk("rst_valid", {31'h0, valid_o}, 32'h0);
      chk("rst_sof",   {31'h0, sof_o}, 32'h0);
      chk("rst_eof",   {31'h0, eof_o}, 32'h0);
      chk("rst_err",   {31'h0, err_o}, 32'h0);
      chk("rst_bc",    {16'h0, byte_count_o}, 32'h0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk_50_mhz);

      // ---------------- 1) nominal 64-byte frame ----------------
      n = build_frame(60, 0);
      clear_capture();
      eof_before = eof_cnt;
      send_frame(8, n, 1'b0, -1, 0, 1'b1);
      repeat (40) @(posedge clk_50_mhz);
      chk("t1_nbytes", got_q.size(), 64);
      chk("t1_data",   data_errs(64), 0);
      chk("t1_sofcnt", sof_cnt, 1);
      chk("t1_sofidx", sof_idx, 0);
      chk("t1_eof",    eof_cnt - eof_before, 1);
      chk("t1_err",    {31'h0, last_err}, 32'h0);
      chk("t1_bc",     {16'h0, byte_count_o}, 64);

      // ---------------- 2) crs_dv toggling over last 2 bytes ----------------
      clear_capture();
      eof_before = eof_cnt;
      send_frame(8, n, 1'b1, -1, 0, 1'b1);
      repeat (40) @(posedge clk_50_mhz);
      chk("t2_nbytes", got_q.size(), 64);
      chk("t2_data",   data_errs(64), 0);
      chk("t2_eof",    eof_cnt - eof_before, 1);
      chk("t2_err",    {31'h0, last_err}, 32'h0);

      // ---------------- 3) rx_er at byte 20 ----------------
      clear_capture();
      eof_before = eof_cnt;
      send_frame(8, n, 1'b0, 20, 0, 1'b1);
      repeat (40) @(posedge clk_50_mhz);
      chk("t3_nbytes", got_q.size(), 64);
      chk("t3_data",   data_errs(64), 0);
      chk("t3_eof",    eof_cnt - eof_before, 1);
      chk("t3_err",    {31'h0, last_err}, 32'h1);

      // ---------------- 4) two trailing dibits (misaligned) ----------------
      clear_capture();
      eof_before = eof_cnt;
      send_frame(8, n, 1'b0, -1, 2, 1'b1);
      repeat (40) @(posedge clk_50_mhz);
      chk("t4_nbytes", got_q.size(), 64);
      chk("t4_eof",    eof_cnt - eof_before, 1);
      chk("t4_err",    {31'h0, last_err}, 32'h1);
      chk("t4_bc",     {16'h0, byte_count_o}, 64);

      // ---------------- 5a) short preamble ----------------
      for (int i = 0; i < 16; i++) fr[i] = 8'(i);
      clear_capture();
      eof_before = eof_cnt;
      send_frame(5, 16, 1'b0, -1, 0, 1'b1);
      repeat (40) @(posedge clk_50_mhz);
      chk("t5_short_valid", got_q.size(), 0);
      chk("t5_short_eof",   eof_cnt - eof_before, 0);

      // ---------------- 5b) oversize 1600-byte frame ----------------
      for (int i = 0; i < 1600; i++) fr[i] = 8'(i);
      clear_capture();
      eof_before = eof_cnt;
      send_frame(8, 1600, 1'b0, -1, 0, 1'b1);
      repeat (40) @(posedge clk_50_mhz);
      chk("t5_big_nbytes", got_q.size(), 1522);
      chk("t5_big_data",   data_errs(1522), 0);
      chk("t5_big_eof",    eof_cnt - eof_before, 1);
      chk("t5_big_err",    {31'h0, last_err}, 32'h1);
      chk("t5_big_bc",     {16'h0, byte_count_o}, 1522);

      // ---------------- 6a) corrupted FCS bit ----------------
      n = build_frame(60, 0);
      fr[62] = fr[62] ^ 8'h08;
      clear_capture();
      eof_before = eof_cnt;
      send_frame(8, n, 1'b0, -1, 0, 1'b1);
      repeat (40) @(posedge clk_50_mhz);
      chk("t6_fcs_nbytes", got_q.size(), 64);
      chk("t6_fcs_eof",    eof_cnt - eof_before, 1);
      chk("t6_fcs_err",    {31'h0, last_err}, {31'h0, FCS_EN});

      // ---------------- 6b) 40-byte runt with valid FCS ----------------
      n = build_frame(36, 8'h80);
      clear_capture();
      eof_before = eof_cnt;
      send_frame(8, n, 1'b0, -1, 0, 1'b1);
      repeat (40) @(posedge clk_50_mhz);
      chk("t6_runt_nbytes", got_q.size(), 40);
      chk("t6_runt_data",   data_errs(40), 0);
      chk("t6_runt_eof",    eof_cnt - eof_before, 1);
      chk("t6_runt_err",    {31'h0, last_err}, {31'h0, FCS_EN});
      chk("t6_runt_bc",     {16'h0, byte_count_o}, 40);

      // ---------------- 6c) reset mid-frame ----------------
      n = build_frame(60, 0);
      clear_capture();
      eof_before = eof_cnt;
      send_frame(8, 10, 1'b0, -1, 0, 1'b0);
      chk("t6_rst_pre_bytes", got_q.size() > 0, 1);
      @(posedge clk_50_mhz);
      #1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk_50_mhz);
      #1;
      chk("t6_rst_data",  {24'h0, data_o}, 32'h0);
      chk("t6_rst_valid", {31'h0, valid_o}, 32'h0);
      chk("t6_rst_bc",    {16'h0, byte_count_o}, 32'h0);
      crs_dv = 1'b0;
      rx_d   = 2'b00;
      rst_n  = 1'b1;
      repeat (40) @(posedge clk_50_mhz);
      chk("t6_rst_no_eof", eof_cnt - eof_before, 0);

      // ---------------- global framing invariants ----------------
      chk("eof_valid_overlap", overlap, 0);
      chk("err_without_eof",   stray_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
